mshr_coalesce: RTL and testbench
================================

MSHR_COALESCE -- requirements
Module: mshr_coalesce

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 4: number of miss entries, must be >= 1.
REQ-002 SHALL have parameter KEY_WIDTH, default 32: line-address key width.
REQ-003 SHALL have parameter TGT_WIDTH, default 8: requester target-id width.
REQ-004 SHALL have parameter N_TARGETS, default 4: maximum targets per entry, must be >= 1.
REQ-005 SHALL have clk_i  input  1  clock, rising edge.
REQ-006 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have flush_i  input  1  synchronous clear of all entries.
REQ-008 SHALL have req_valid_i / req_ready_o  in/out  1  miss-request handshake.
REQ-009 SHALL have req_key_i  input  KEY_WIDTH  and  req_tgt_i  input  TGT_WIDTH  for the request line key and target id.
REQ-010 SHALL have req_idx_o  output  clog2(N_ENTRIES) (min 1)  entry taking the request, and req_merged_o  output  1  high when the request merged.
REQ-011 SHALL have issue_valid_o / issue_ready_i  out/in  1, plus issue_key_o  KEY_WIDTH  and issue_idx_o  idx-width: memory request.
REQ-012 SHALL have refill_valid_i  input  1  and refill_idx_i  input  idx-width: memory response.
REQ-013 SHALL have replay_valid_o / replay_ready_i  out/in  1, plus replay_key_o, replay_tgt_o, replay_idx_o: target wake-up.
REQ-014 SHALL have full_o  output  1  (no FREE entry) and count_o  output  clog2(N_ENTRIES+1)  (non-FREE entries).

Function
REQ-015 Each entry SHALL hold a state FREE, WAIT_ISSUE, INFLIGHT or REPLAY, a key, a target FIFO of N_TARGETS ids and a target count.
REQ-016 A request SHALL merge when its key equals the key of an entry in WAIT_ISSUE or INFLIGHT and that entry's count < N_TARGETS; the target is appended and the entry state is unchanged.
REQ-017 A request matching an entry in REPLAY, or matching an entry with a full target list, SHALL stall (req_ready_o=0).
REQ-018 A request with no matching key SHALL allocate the lowest-index FREE entry into WAIT_ISSUE with count=1; if no entry is FREE then req_ready_o=0.
REQ-019 Entries freed in cycle t SHALL be allocatable only from cycle t+1; req_ready_o SHALL depend only on registered state and request inputs.
REQ-020 req_idx_o and req_merged_o SHALL be valid combinationally whenever req_valid_i && req_ready_o.
REQ-021 issue_valid_o SHALL assert when any entry is in WAIT_ISSUE, presenting the lowest-index such entry; on issue_ready_i, that entry moves to INFLIGHT at the next edge.
REQ-022 refill_valid_i SHALL move entry refill_idx_i from INFLIGHT to REPLAY; a refill to an entry in any other state SHALL be ignored.
REQ-023 A merge and a refill to the same entry in the same cycle SHALL both take effect; the merged target is replayed.
REQ-024 replay_valid_o SHALL present the oldest target of the lowest-index REPLAY entry; each replay_ready_i pops one target per cycle, in arrival order.
REQ-025 The entry SHALL return to FREE on the edge that pops its last target.
REQ-026 issue_* and replay_* outputs SHALL hold stable while valid is high and ready is low.
REQ-027 flush_i SHALL return all entries to FREE at the next edge, overriding every other event in that cycle; later refills to those entries SHALL be ignored per REQ-022.

Reset
REQ-028 On rst_ni low, all entries SHALL be FREE and all keys, targets and counts zero, asynchronously.
REQ-029 Outputs in reset SHALL be: req_ready_o=1, req_merged_o=0, req_idx_o=0, issue_valid_o=0, replay_valid_o=0, full_o=0, count_o=0, and all data outputs 0.

Configuration
REQ-030 Macro MSHR_COALESCE_MERGE_EN SHALL control secondary-miss merging.
REQ-031 With MSHR_COALESCE_MERGE_EN defined, REQ-016 applies.
REQ-032 Without MSHR_COALESCE_MERGE_EN, any key match against a non-FREE entry SHALL stall, req_merged_o SHALL be tied 0, and every entry SHALL hold exactly one target.

Verification
REQ-033 Alloc key 0x100 tgt 1 with issue_ready_i=1 -> idx 0 issued next cycle, INFLIGHT; refill idx 0 -> replay tgt 1, key 0x100; entry FREE; count_o returns to 0.
REQ-034 Merge (MERGE_EN): keys 0x100 tgt 1,2,3,4,5 back-to-back -> tgt 2-4 merged into idx 0 with req_merged_o=1; tgt 5 stalls; after refill, replay order is 1,2,3,4.
REQ-035 Full: 4 distinct keys allocate idx 0-3 -> full_o=1, count_o=4; a 5th distinct key stalls until an entry finishes replay, then takes that index one cycle later.
REQ-036 Same-cycle refill of idx 0 plus merge tgt 9 on its key -> both accepted; replay emits the existing targets then 9.
REQ-037 Flush with entries in WAIT_ISSUE and INFLIGHT -> count_o=0 next cycle; a subsequent refill to the old idx produces no replay.
REQ-038 Assert rst_ni low mid-replay with replay_ready_i=0 -> outputs at reset values immediately, no target replayed after release.

Source files
------------

// File: rtl/mshr_coalesce_if.sv
// mshr_coalesce_if
//   Bundles the request, issue, refill, replay and status signals of the
//   miss-status holding register block. Signal suffixes (_i/_o) are named
//   from the MSHR's point of view.
//   Modports:
//     slave  - the MSHR itself (mshr_coalesce)
//     master - whatever drives requests/refills and consumes issue/replay
//   Parameters must match the widths derived inside mshr_coalesce:
//     IDX_WIDTH = max(1, clog2(N_ENTRIES)), CNT_WIDTH = clog2(N_ENTRIES+1).
interface mshr_coalesce_if #(
  parameter int KEY_WIDTH = 32,
  parameter int TGT_WIDTH = 8,
  parameter int IDX_WIDTH = 2,
  parameter int CNT_WIDTH = 3
);
  logic                 flush_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [KEY_WIDTH-1:0] req_key_i;
  logic [TGT_WIDTH-1:0] req_tgt_i;
  logic [IDX_WIDTH-1:0] req_idx_o;
  logic                 req_merged_o;
  logic                 issue_valid_o;
  logic                 issue_ready_i;
  logic [KEY_WIDTH-1:0] issue_key_o;
  logic [IDX_WIDTH-1:0] issue_idx_o;
  logic                 refill_valid_i;
  logic [IDX_WIDTH-1:0] refill_idx_i;
  logic                 replay_valid_o;
  logic                 replay_ready_i;
  logic [KEY_WIDTH-1:0] replay_key_o;
  logic [TGT_WIDTH-1:0] replay_tgt_o;
  logic [IDX_WIDTH-1:0] replay_idx_o;
  logic                 full_o;
  logic [CNT_WIDTH-1:0] count_o;

  modport slave (
    input  flush_i, req_valid_i, req_key_i, req_tgt_i, issue_ready_i,
           refill_valid_i, refill_idx_i, replay_ready_i,
    output req_ready_o, req_idx_o, req_merged_o, issue_valid_o, issue_key_o,
           issue_idx_o, replay_valid_o, replay_key_o, replay_tgt_o,
           replay_idx_o, full_o, count_o
  );

  modport master (
    output flush_i, req_valid_i, req_key_i, req_tgt_i, issue_ready_i,
           refill_valid_i, refill_idx_i, replay_ready_i,
    input  req_ready_o, req_idx_o, req_merged_o, issue_valid_o, issue_key_o,
           issue_idx_o, replay_valid_o, replay_key_o, replay_tgt_o,
           replay_idx_o, full_o, count_o
  );
endinterface

// File: rtl/mshr_coalesce.sv
// mshr_coalesce
//   Miss-status holding registers with optional secondary-miss coalescing.
//   Each entry tracks one outstanding line: FREE -> WAIT_ISSUE -> INFLIGHT
//   -> REPLAY -> FREE, with a FIFO of requester target ids that are woken
//   up one per cycle after the refill arrives.
//   Ports:
//     clk_i   - clock, rising edge
//     rst_ni  - asynchronous active-low reset
//     bus     - mshr_coalesce_if.slave: flush, request (valid/ready, key,
//               target, idx, merged), issue (valid/ready, key, idx), refill
//               (valid, idx), replay (valid/ready, key, tgt, idx), full, count
//   Configuration macro:
//     MSHR_COALESCE_MERGE_EN - when defined, requests hitting a WAIT_ISSUE or
//       INFLIGHT entry with room append their target. When undefined, every
//       key hit stalls and each entry holds exactly one target.
module mshr_coalesce #(
  parameter int N_ENTRIES = 4,
  parameter int KEY_WIDTH = 32,
  parameter int TGT_WIDTH = 8,
  parameter int N_TARGETS = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  mshr_coalesce_if.slave bus
);

`ifdef MSHR_COALESCE_MERGE_EN
  localparam bit MERGE_EN = 1'b1;
`else
  localparam bit MERGE_EN = 1'b0;
`endif

  localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CNT_W    = $clog2(N_ENTRIES + 1);
  localparam int EFF_TGTS = MERGE_EN ? N_TARGETS : 1;
  localparam int TC_W     = $clog2(EFF_TGTS + 1);

  typedef enum logic [1:0] {FREE, WAIT_ISSUE, INFLIGHT, REPLAY} entry_state_e;

  entry_state_e         state_q [N_ENTRIES];
  entry_state_e         state_d [N_ENTRIES];
  logic [KEY_WIDTH-1:0] key_q   [N_ENTRIES];
  logic [KEY_WIDTH-1:0] key_d   [N_ENTRIES];
  logic [TGT_WIDTH-1:0] tgt_q   [N_ENTRIES][EFF_TGTS];
  logic [TGT_WIDTH-1:0] tgt_d   [N_ENTRIES][EFF_TGTS];
  logic [TC_W-1:0]      tcnt_q  [N_ENTRIES];
  logic [TC_W-1:0]      tcnt_d  [N_ENTRIES];

  // Locks keep the presented issue/replay entry stable while the consumer
  // back-pressures, even if a lower-index entry becomes eligible meanwhile.
  logic             issue_lock_q, issue_lock_d;
  logic [IDX_W-1:0] issue_lock_idx_q, issue_lock_idx_d;
  logic             replay_lock_q, replay_lock_d;
  logic [IDX_W-1:0] replay_lock_idx_q, replay_lock_idx_d;

  logic             hit, free_any, wait_any, repl_any, merge_ok, accept;
  logic [IDX_W-1:0] hit_idx, free_idx, wait_idx, repl_idx;
  logic [IDX_W-1:0] issue_sel, replay_sel;
  logic [CNT_W-1:0] busy_cnt;
  logic             issue_valid, replay_valid, issue_fire, replay_fire;

  // Key lookup and priority encoders; loops run high-to-low so the last
  // assignment wins with the lowest index.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    wait_any = 1'b0;
    wait_idx = '0;
    repl_any = 1'b0;
    repl_idx = '0;
    busy_cnt = '0;
    for (int e = N_ENTRIES - 1; e >= 0; e--) begin
      if (state_q[e] == FREE) begin
        free_any = 1'b1;
        free_idx = IDX_W'(e);
      end else begin
        busy_cnt = busy_cnt + CNT_W'(1);
        if (key_q[e] == bus.req_key_i) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(e);
        end
      end
      if (state_q[e] == WAIT_ISSUE) begin
        wait_any = 1'b1;
        wait_idx = IDX_W'(e);
      end
      if (state_q[e] == REPLAY) begin
        repl_any = 1'b1;
        repl_idx = IDX_W'(e);
      end
    end
  end

`ifdef MSHR_COALESCE_MERGE_EN
  assign merge_ok = hit &&
                    ((state_q[hit_idx] == WAIT_ISSUE) || (state_q[hit_idx] == INFLIGHT)) &&
                    (tcnt_q[hit_idx] < TC_W'(N_TARGETS));
`else
  assign merge_ok = 1'b0;
`endif

  // Readiness uses registered state only, so an entry freed this cycle is
  // not visible to allocation until the next one.
  assign bus.req_ready_o = hit ? merge_ok : free_any;
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign bus.req_idx_o   = accept ? (hit ? hit_idx : free_idx) : '0;
`ifdef MSHR_COALESCE_MERGE_EN
  assign bus.req_merged_o = accept && hit;
`else
  assign bus.req_merged_o = 1'b0;
`endif

  assign issue_valid       = issue_lock_q || wait_any;
  assign issue_sel         = issue_lock_q ? issue_lock_idx_q : wait_idx;
  assign issue_fire        = issue_valid && bus.issue_ready_i;
  assign bus.issue_valid_o = issue_valid;
  assign bus.issue_key_o   = issue_valid ? key_q[issue_sel] : '0;
  assign bus.issue_idx_o   = issue_valid ? issue_sel : '0;

  assign replay_valid       = replay_lock_q || repl_any;
  assign replay_sel         = replay_lock_q ? replay_lock_idx_q : repl_idx;
  assign replay_fire        = replay_valid && bus.replay_ready_i;
  assign bus.replay_valid_o = replay_valid;
  assign bus.replay_key_o   = replay_valid ? key_q[replay_sel] : '0;
  assign bus.replay_tgt_o   = replay_valid ? tgt_q[replay_sel][0] : '0;
  assign bus.replay_idx_o   = replay_valid ? replay_sel : '0;

  assign bus.full_o  = !free_any;
  assign bus.count_o = busy_cnt;

  // Next-state for all entries. Issue, refill, replay and request touch
  // entries in distinct states, so they never collide except merge+refill,
  // which update independent fields. Flush is applied last to override all.
  always_comb begin
    for (int e = 0; e < N_ENTRIES; e++) begin
      state_d[e] = state_q[e];
      key_d[e]   = key_q[e];
      tcnt_d[e]  = tcnt_q[e];
      for (int k = 0; k < EFF_TGTS; k++) begin
        tgt_d[e][k] = tgt_q[e][k];
      end
    end
    issue_lock_d      = issue_valid && !bus.issue_ready_i && !bus.flush_i;
    issue_lock_idx_d  = issue_sel;
    replay_lock_d     = replay_valid && !bus.replay_ready_i && !bus.flush_i;
    replay_lock_idx_d = replay_sel;

    if (issue_fire) begin
      state_d[issue_sel] = INFLIGHT;
    end

    if (bus.refill_valid_i && (int'(bus.refill_idx_i) < N_ENTRIES)) begin
      if (state_q[bus.refill_idx_i] == INFLIGHT) begin
        state_d[bus.refill_idx_i] = REPLAY;
      end
    end

    // Pop shifts the FIFO toward slot 0 so the head is always slot 0.
    if (replay_fire) begin
      for (int k = 0; k < EFF_TGTS - 1; k++) begin
        tgt_d[replay_sel][k] = tgt_q[replay_sel][k+1];
      end
      tgt_d[replay_sel][EFF_TGTS-1] = '0;
      tcnt_d[replay_sel] = tcnt_q[replay_sel] - TC_W'(1);
      if (tcnt_q[replay_sel] == TC_W'(1)) begin
        state_d[replay_sel] = FREE;
      end
    end

    if (accept && !hit) begin
      state_d[free_idx]  = WAIT_ISSUE;
      key_d[free_idx]    = bus.req_key_i;
      tgt_d[free_idx][0] = bus.req_tgt_i;
      tcnt_d[free_idx]   = TC_W'(1);
    end
`ifdef MSHR_COALESCE_MERGE_EN
    if (accept && hit) begin
      tgt_d[hit_idx][tcnt_q[hit_idx]] = bus.req_tgt_i;
      tcnt_d[hit_idx] = tcnt_q[hit_idx] + TC_W'(1);
    end
`endif

    if (bus.flush_i) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        state_d[e] = FREE;
        tcnt_d[e]  = '0;
        for (int k = 0; k < EFF_TGTS; k++) begin
          tgt_d[e][k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        state_q[e] <= FREE;
        key_q[e]   <= '0;
        tcnt_q[e]  <= '0;
        for (int k = 0; k < EFF_TGTS; k++) begin
          tgt_q[e][k] <= '0;
        end
      end
      issue_lock_q      <= 1'b0;
      issue_lock_idx_q  <= '0;
      replay_lock_q     <= 1'b0;
      replay_lock_idx_q <= '0;
    end else begin
      for (int e = 0; e < N_ENTRIES; e++) begin
        state_q[e] <= state_d[e];
        key_q[e]   <= key_d[e];
        tcnt_q[e]  <= tcnt_d[e];
        for (int k = 0; k < EFF_TGTS; k++) begin
          tgt_q[e][k] <= tgt_d[e][k];
        end
      end
      issue_lock_q      <= issue_lock_d;
      issue_lock_idx_q  <= issue_lock_idx_d;
      replay_lock_q     <= replay_lock_d;
      replay_lock_idx_q <= replay_lock_idx_d;
    end
  end

endmodule

// File: tb/tb_mshr_coalesce.sv
// tb_mshr_coalesce
//   Directed bench for mshr_coalesce (N_ENTRIES=4, KEY_WIDTH=32,
//   TGT_WIDTH=8, N_TARGETS=4). Inputs change 1ns after the rising edge and
//   outputs are sampled 2ns after it. Merge-specific sequences are selected
//   by MSHR_COALESCE_MERGE_EN, matching the build of the design.
module tb_mshr_coalesce;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mshr_coalesce_if #(.KEY_WIDTH(32), .TGT_WIDTH(8), .IDX_WIDTH(2), .CNT_WIDTH(3)) bus ();

  mshr_coalesce #(
    .N_ENTRIES(4),
    .KEY_WIDTH(32),
    .TGT_WIDTH(8),
    .N_TARGETS(4)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] key, input logic [7:0] tgt);
    bus.req_valid_i = valid;
    bus.req_key_i   = key;
    bus.req_tgt_i   = tgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.flush_i        = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_key_i      = '0;
    bus.req_tgt_i      = '0;
    bus.issue_ready_i  = 1'b0;
    bus.refill_valid_i = 1'b0;
    bus.refill_idx_i   = '0;
    bus.replay_ready_i = 1'b0;
    #3;

    // Reset values
    checkOutput("rst_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("rst_merged", 32'(bus.req_merged_o), 32'd0);
    checkOutput("rst_idx", 32'(bus.req_idx_o), 32'd0);
    checkOutput("rst_issue_valid", 32'(bus.issue_valid_o), 32'd0);
    checkOutput("rst_replay_valid", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("rst_full", 32'(bus.full_o), 32'd0);
    checkOutput("rst_count", 32'(bus.count_o), 32'd0);
    checkOutput("rst_issue_key", bus.issue_key_o, 32'd0);
    checkOutput("rst_replay_tgt", 32'(bus.replay_tgt_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] basic alloc/issue/refill/replay");
    bus.issue_ready_i = 1'b1;
    applyStimulus(1'b1, 32'h100, 8'd1);
    checkOutput("b_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("b_idx", 32'(bus.req_idx_o), 32'd0);
    checkOutput("b_merged", 32'(bus.req_merged_o), 32'd0);
    tick();
    applyStimulus(1'b0, 32'h0, 8'd0);
    checkOutput("b_issue_valid", 32'(bus.issue_valid_o), 32'd1);
    checkOutput("b_issue_key", bus.issue_key_o, 32'h100);
    checkOutput("b_issue_idx", 32'(bus.issue_idx_o), 32'd0);
    checkOutput("b_count1", 32'(bus.count_o), 32'd1);
    tick();
    bus.issue_ready_i = 1'b0;
    checkOutput("b_inflight_no_issue", 32'(bus.issue_valid_o), 32'd0);
    checkOutput("b_inflight_count", 32'(bus.count_o), 32'd1);
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    tick();
    bus.refill_valid_i = 1'b0;
    #1;
    checkOutput("b_replay_valid", 32'(bus.replay_valid_o), 32'd1);
    checkOutput("b_replay_tgt", 32'(bus.replay_tgt_o), 32'd1);
    checkOutput("b_replay_key", bus.replay_key_o, 32'h100);
    checkOutput("b_replay_idx", 32'(bus.replay_idx_o), 32'd0);
    tick();
    checkOutput("b_replay_hold", 32'(bus.replay_tgt_o), 32'd1);
    bus.replay_ready_i = 1'b1;
    tick();
    bus.replay_ready_i = 1'b0;
    #1;
    checkOutput("b_free_replay", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("b_free_count", 32'(bus.count_o), 32'd0);

    $display("[TB] full and alloc-after-free");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i), 8'(10 + i));
      checkOutput("f_ready", 32'(bus.req_ready_o), 32'd1);
      checkOutput("f_idx", 32'(bus.req_idx_o), 32'(i));
      tick();
    end
    applyStimulus(1'b1, 32'h300, 8'd14);
    checkOutput("f_full", 32'(bus.full_o), 32'd1);
    checkOutput("f_count4", 32'(bus.count_o), 32'd4);
    checkOutput("f_stall", 32'(bus.req_ready_o), 32'd0);
    checkOutput("f_issue_idx0", 32'(bus.issue_idx_o), 32'd0);
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i  = 1'b0;
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    tick();
    bus.refill_valid_i = 1'b0;
    #1;
    checkOutput("f_replay_tgt", 32'(bus.replay_tgt_o), 32'd10);
    bus.replay_ready_i = 1'b1;
    #1;
    checkOutput("f_stall_on_free_cycle", 32'(bus.req_ready_o), 32'd0);
    tick();
    bus.replay_ready_i = 1'b0;
    #1;
    checkOutput("f_ready_after_free", 32'(bus.req_ready_o), 32'd1);
    checkOutput("f_reuse_idx", 32'(bus.req_idx_o), 32'd0);
    checkOutput("f_count3", 32'(bus.count_o), 32'd3);
    tick();
    applyStimulus(1'b0, 32'h0, 8'd0);
    checkOutput("f_count4_again", 32'(bus.count_o), 32'd4);
    // entry 1 was presented under back-pressure before entry 0 re-allocated
    checkOutput("f_issue_stable", 32'(bus.issue_idx_o), 32'd1);
    checkOutput("f_issue_key_stable", bus.issue_key_o, 32'h201);

    $display("[TB] flush");
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i = 1'b0;
    bus.flush_i       = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    #1;
    checkOutput("fl_count", 32'(bus.count_o), 32'd0);
    checkOutput("fl_full", 32'(bus.full_o), 32'd0);
    checkOutput("fl_issue_valid", 32'(bus.issue_valid_o), 32'd0);
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd1;
    tick();
    bus.refill_valid_i = 1'b0;
    #1;
    checkOutput("fl_no_replay", 32'(bus.replay_valid_o), 32'd0);
    tick();
    checkOutput("fl_no_replay2", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("fl_count_still0", 32'(bus.count_o), 32'd0);

`ifdef MSHR_COALESCE_MERGE_EN
    $display("[TB] merge up to capacity");
    applyStimulus(1'b1, 32'h100, 8'd1);
    checkOutput("m_alloc_merged", 32'(bus.req_merged_o), 32'd0);
    tick();
    for (int t = 2; t <= 4; t++) begin
      applyStimulus(1'b1, 32'h100, 8'(t));
      checkOutput("m_ready", 32'(bus.req_ready_o), 32'd1);
      checkOutput("m_idx", 32'(bus.req_idx_o), 32'd0);
      checkOutput("m_merged", 32'(bus.req_merged_o), 32'd1);
      tick();
    end
    applyStimulus(1'b1, 32'h100, 8'd5);
    checkOutput("m_full_list_stall", 32'(bus.req_ready_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i  = 1'b0;
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    tick();
    bus.refill_valid_i = 1'b0;
    bus.replay_ready_i = 1'b1;
    #1;
    for (int t = 1; t <= 4; t++) begin
      checkOutput("m_replay_valid", 32'(bus.replay_valid_o), 32'd1);
      checkOutput("m_replay_order", 32'(bus.replay_tgt_o), 32'(t));
      tick();
    end
    bus.replay_ready_i = 1'b0;
    #1;
    checkOutput("m_drained", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("m_count0", 32'(bus.count_o), 32'd0);

    $display("[TB] merge concurrent with refill");
    applyStimulus(1'b1, 32'h500, 8'd7);
    tick();
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i = 1'b0;
    applyStimulus(1'b1, 32'h500, 8'd8);
    checkOutput("c_merge_inflight", 32'(bus.req_merged_o), 32'd1);
    tick();
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    applyStimulus(1'b1, 32'h500, 8'd9);
    checkOutput("c_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("c_merged", 32'(bus.req_merged_o), 32'd1);
    tick();
    bus.refill_valid_i = 1'b0;
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.replay_ready_i = 1'b1;
    #1;
    checkOutput("c_replay0", 32'(bus.replay_tgt_o), 32'd7);
    tick();
    checkOutput("c_replay1", 32'(bus.replay_tgt_o), 32'd8);
    tick();
    checkOutput("c_replay2", 32'(bus.replay_tgt_o), 32'd9);
    tick();
    bus.replay_ready_i = 1'b0;
    #1;
    checkOutput("c_drained", 32'(bus.replay_valid_o), 32'd0);
`else
    $display("[TB] key hit stalls without merging");
    applyStimulus(1'b1, 32'h100, 8'd1);
    checkOutput("n_alloc_ready", 32'(bus.req_ready_o), 32'd1);
    tick();
    applyStimulus(1'b1, 32'h100, 8'd2);
    checkOutput("n_hit_stall", 32'(bus.req_ready_o), 32'd0);
    checkOutput("n_merged_tied", 32'(bus.req_merged_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i  = 1'b0;
    applyStimulus(1'b1, 32'h100, 8'd3);
    checkOutput("n_inflight_stall", 32'(bus.req_ready_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    tick();
    bus.refill_valid_i = 1'b0;
    bus.replay_ready_i = 1'b1;
    #1;
    checkOutput("n_replay_tgt", 32'(bus.replay_tgt_o), 32'd1);
    tick();
    bus.replay_ready_i = 1'b0;
    #1;
    checkOutput("n_single_target", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("n_count0", 32'(bus.count_o), 32'd0);
`endif

    $display("[TB] reset during replay");
    applyStimulus(1'b1, 32'h700, 8'd3);
    tick();
    applyStimulus(1'b0, 32'h0, 8'd0);
    bus.issue_ready_i = 1'b1;
    tick();
    bus.issue_ready_i  = 1'b0;
    bus.refill_valid_i = 1'b1;
    bus.refill_idx_i   = 2'd0;
    tick();
    bus.refill_valid_i = 1'b0;
    #1;
    checkOutput("r_replay_pending", 32'(bus.replay_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("r_async_replay", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("r_async_count", 32'(bus.count_o), 32'd0);
    checkOutput("r_async_ready", 32'(bus.req_ready_o), 32'd1);
    checkOutput("r_async_tgt", 32'(bus.replay_tgt_o), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.replay_ready_i = 1'b1;
    tick();
    tick();
    checkOutput("r_no_replay_after", 32'(bus.replay_valid_o), 32'd0);
    checkOutput("r_count_after", 32'(bus.count_o), 32'd0);
    bus.replay_ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
